// File: rtl/servo_sequencer.sv
// servo_sequencer: debounced push-button front end and frame-locked 0/90 degree
// sweep sequencer that feeds the servo PWM generator (enable + angle select).
module servo_sequencer #(
    parameter int FRAME_CLKS    = 1000000,
    parameter int DEBOUNCE_CLKS = 500000,
    parameter int HOLD_FRAMES   = 50,
    parameter int CYCLES        = 3
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       abort,
    output logic       main_program,
    output logic       control_input,
    output logic       busy,
    output logic       done,
    output logic [7:0] cycles_done
);

    localparam int DB_W = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CLKS - 1);
    localparam logic [19:0]     FR_LAST   = 20'(FRAME_CLKS - 1);
    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]      CYC_LAST  = 8'(CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_POS90,
        S_POS0,
        S_DONE
    } state_t;

    state_t          state;
    logic            btn_sync1;
    logic            btn_s;
    logic            btn_db;
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic [19:0]     fr_cnt;
    logic [7:0]      hold_cnt;
    logic            start;
    logic            frame_tick;
    logic            hold_done;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge mclk) begin
        if (reset) begin
            btn_sync1 <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            btn_sync1 <= btn_raw;
            btn_s     <= btn_sync1;
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE_CLKS clocks
    always_ff @(posedge mclk) begin
        if (reset) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Only a press (rising debounced edge) starts a run; a held button never re-fires
    assign start      = btn_db & ~btn_db_q;
    assign frame_tick = (fr_cnt == FR_LAST);
    assign hold_done  = frame_tick && (hold_cnt == HOLD_LAST);

    // Sequencer: frame/hold timers and state advance, all outputs registered with the state
    always_ff @(posedge mclk) begin
        if (reset) begin
            state         <= S_IDLE;
            main_program  <= 1'b0;
            control_input <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cycles_done   <= '0;
            fr_cnt        <= '0;
            hold_cnt      <= '0;
        end else begin
            done <= 1'b0;

            // Timers sit at 0 while the PWM stage is disabled so the first frame
            // of a run lines up with the PWM counter leaving 0.
            if (state == S_IDLE || state == S_DONE) begin
                fr_cnt   <= '0;
                hold_cnt <= '0;
            end else begin
                fr_cnt <= frame_tick ? '0 : fr_cnt + 20'd1;
                if (frame_tick)
                    hold_cnt <= hold_done ? '0 : hold_cnt + 8'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state         <= S_ARM;
                        main_program  <= 1'b1;
                        control_input <= 1'b0;
                        busy          <= 1'b1;
                        cycles_done   <= '0;
                    end
                end
                S_ARM, S_POS90, S_POS0: begin
                    if (abort) begin
                        // Abort leaves cycles_done as a record of how far the run got
                        state         <= S_IDLE;
                        main_program  <= 1'b0;
                        control_input <= 1'b0;
                        busy          <= 1'b0;
                        fr_cnt        <= '0;
                        hold_cnt      <= '0;
                    end else if (hold_done) begin
                        // hold_done only fires on a frame wrap, so the angle never
                        // changes mid-pulse
                        if (state == S_ARM) begin
                            state         <= S_POS90;
                            control_input <= 1'b1;
                        end else if (state == S_POS90) begin
                            state         <= S_POS0;
                            control_input <= 1'b0;
                        end else begin
                            if (cycles_done != 8'hFF)
                                cycles_done <= cycles_done + 8'd1;
                            if (cycles_done == CYC_LAST) begin
                                state         <= S_DONE;
                                main_program  <= 1'b0;
                                control_input <= 1'b0;
                                done          <= 1'b1;
                            end else begin
                                state         <= S_POS90;
                                control_input <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_sequencer.sv
// Bench for servo_sequencer: a timeline reference model (run position k since the
// enable rose) checked every clock, a table of expected outputs along a full run,
// hand-written corner sequences and a randomized button/abort/reset phase.
module tb_servo_sequencer;

    localparam int FR    = 10;
    localparam int DB    = 4;
    localparam int HF    = 2;
    localparam int CY    = 2;
    localparam int SEG   = FR * HF;            // clocks per position
    localparam int TOTAL = SEG * (1 + 2 * CY); // clocks with main_program high

    logic       mclk    = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_raw = 1'b0;
    logic       abort   = 1'b0;
    logic       main_program, control_input, busy, done;
    logic [7:0] cycles_done;

    int n_checks = 0;
    int n_fail   = 0;

    servo_sequencer #(
        .FRAME_CLKS(FR), .DEBOUNCE_CLKS(DB), .HOLD_FRAMES(HF), .CYCLES(CY)
    ) dut (
        .mclk(mclk), .reset(reset), .btn_raw(btn_raw), .abort(abort),
        .main_program(main_program), .control_input(control_input),
        .busy(busy), .done(done), .cycles_done(cycles_done)
    );

    always #5 mclk = ~mclk;

    // ---------------- reference model ----------------
    // Button: two-clock synchroniser, then a level is accepted after DB consecutive
    // differing samples. Run: position k counts clocks since enable rose; outputs
    // follow from which SEG-long segment k falls in (ARM, 90, 0, 90, 0, ...).
    logic m_s1 = 0, m_s2 = 0, m_db = 0, m_dbq = 0;
    int   m_run = 0;
    bit   m_act = 0;
    int   m_k   = 0;
    int   m_cd  = 0;

    function automatic int cd_at(int k);
        int s;
        s = k / SEG;
        return (s == 0) ? 0 : (((s - 1) / 2 > 255) ? 255 : (s - 1) / 2);
    endfunction

    task automatic model_update();
        logic st;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0; m_run = 0;
            m_act = 0; m_k = 0; m_cd = 0;
        end else begin
            st = m_db & ~m_dbq;
            if (m_act) begin
                if (m_k == TOTAL || abort) begin
                    m_act = 0;
                    m_cd  = cd_at(m_k);
                end else begin
                    m_k++;
                end
            end else if (st && !abort) begin
                m_act = 1; m_k = 0; m_cd = 0;
            end
            m_dbq = m_db;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db  = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        logic       e_mp, e_ci, e_bz, e_dn;
        logic [7:0] e_cd;
        @(posedge mclk);
        model_update();
        @(negedge mclk);
        e_mp = m_act && (m_k < TOTAL);
        e_ci = e_mp && (((m_k / SEG) % 2) == 1);
        e_bz = m_act;
        e_dn = m_act && (m_k == TOTAL);
        e_cd = 8'(m_act ? cd_at(m_k) : m_cd);
        n_checks++;
        if ({main_program, control_input, busy, done, cycles_done} !==
            {e_mp, e_ci, e_bz, e_dn, e_cd}) begin
            n_fail++;
            $display("FAIL model @%0t: mp,ci,busy,done=%b%b%b%b cd=%0d, expected %b%b%b%b cd=%0d",
                     $time, main_program, control_input, busy, done, cycles_done,
                     e_mp, e_ci, e_bz, e_dn, e_cd);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Step until main_program rises; returns the number of edges taken or -1.
    task automatic wait_rise(output int n);
        n = 0;
        while (!main_program && n < 40) begin
            step();
            n++;
        end
        if (!main_program) n = -1;
    endtask

    // ---------------- expected outputs along a full run ----------------
    typedef struct {
        int   k;      // clocks after main_program rose, button held down
        logic mp;
        logic ci;
        logic bz;
        logic dn;
        int   cd;
    } vec_t;

    function automatic vec_t mk(int k, logic mp, logic ci, logic bz, logic dn, int cd);
        vec_t v;
        v.k = k; v.mp = mp; v.ci = ci; v.bz = bz; v.dn = dn; v.cd = cd;
        return v;
    endfunction

    vec_t       tbl[$];
    logic       mp_h[0:119];
    logic       ci_h[0:119];
    logic       bz_h[0:119];
    logic       dn_h[0:119];
    logic [7:0] cd_h[0:119];

    initial begin
        int edges, seen, cnt, bad, len, dn_at;

        tbl.push_back(mk(  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk( 19, 1, 0, 1, 0, 0));
        tbl.push_back(mk( 20, 1, 1, 1, 0, 0));
        tbl.push_back(mk( 39, 1, 1, 1, 0, 0));
        tbl.push_back(mk( 40, 1, 0, 1, 0, 0));
        tbl.push_back(mk( 59, 1, 0, 1, 0, 0));
        tbl.push_back(mk( 60, 1, 1, 1, 0, 1));
        tbl.push_back(mk( 79, 1, 1, 1, 0, 1));
        tbl.push_back(mk( 80, 1, 0, 1, 0, 1));
        tbl.push_back(mk( 99, 1, 0, 1, 0, 1));
        tbl.push_back(mk(100, 0, 0, 1, 1, 2));
        tbl.push_back(mk(101, 0, 0, 0, 0, 2));
        tbl.push_back(mk(115, 0, 0, 0, 0, 2));

        // reset state
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_state", int'({main_program, control_input, busy, done, cycles_done}), 0);

        // glitch: three clocks high is one short of acceptance
        btn_raw = 1'b1;
        repeat (3) step();
        btn_raw = 1'b0;
        seen = 0;
        repeat (50) begin
            step();
            if (main_program) seen = 1;
        end
        chk("glitch_reject", seen, 0);

        // full run with button held
        btn_raw = 1'b1;
        wait_rise(edges);
        chk("start_latency_edges", edges, DB + 3);
        for (int k = 0; k < 120; k++) begin
            if (k > 0) step();
            mp_h[k] = main_program; ci_h[k] = control_input; bz_h[k] = busy;
            dn_h[k] = done;         cd_h[k] = cycles_done;
        end
        foreach (tbl[i]) begin
            chk($sformatf("run_vec_k%0d", tbl[i].k),
                int'({mp_h[tbl[i].k], ci_h[tbl[i].k], bz_h[tbl[i].k], dn_h[tbl[i].k], cd_h[tbl[i].k]}),
                int'({tbl[i].mp, tbl[i].ci, tbl[i].bz, tbl[i].dn, 8'(tbl[i].cd)}));
        end
        cnt = 0; bad = 0; len = 0;
        for (int k = 0; k < 120; k++) begin
            if (mp_h[k]) cnt++;
            if (dn_h[k]) len++;
            if (k > 0 && ci_h[k] != ci_h[k-1] && (k % FR) != 0) bad++;
        end
        chk("mp_high_clks", cnt, TOTAL);
        chk("done_pulse_count", len, 1);
        chk("ci_moves_off_frame_wrap", bad, 0);
        btn_raw = 1'b0;
        repeat (20) step();

        // abort at clock 25 of a run
        btn_raw = 1'b1;
        wait_rise(edges);
        chk("abort_run_start", edges, DB + 3);
        repeat (25) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", int'({main_program, control_input, busy, done, cycles_done}), 0);
        seen = 0;
        repeat (120) begin
            step();
            if (done || main_program) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        btn_raw = 1'b0;
        repeat (20) step();

        // second press during a run is ignored
        btn_raw = 1'b1;
        wait_rise(edges);
        len = 0; dn_at = -1;
        for (int k = 0; k < 130; k++) begin
            if (k == 10) btn_raw = 1'b0;
            if (k == 30) btn_raw = 1'b1;
            if (main_program) len++;
            if (done) dn_at = k;
            step();
        end
        chk("retrigger_run_len", len, TOTAL);
        chk("retrigger_done_at", dn_at, TOTAL);
        chk("cd_held_after_done", cycles_done, CY);
        btn_raw = 1'b0;
        repeat (20) step();
        btn_raw = 1'b1;
        wait_rise(edges);
        chk("rerun_start_edges", edges, DB + 3);
        chk("rerun_cd_restart", cycles_done, 0);
        repeat (110) step();
        chk("rerun_cd_final", cycles_done, CY);
        btn_raw = 1'b0;
        repeat (20) step();

        // abort held across the debounced start edge
        abort = 1'b1;
        btn_raw = 1'b1;
        seen = 0;
        repeat (30) begin
            step();
            if (main_program || busy) seen = 1;
        end
        abort = 1'b0;
        repeat (20) begin
            step();
            if (main_program || busy) seen = 1;
        end
        chk("abort_beats_start", seen, 0);
        btn_raw = 1'b0;
        repeat (20) step();

        // randomized button bounce, aborts and resets against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 8) btn_raw = ~btn_raw;
            abort = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset = 1'b0;
        abort = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
